// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among N valid/ready requesters.
// Reads are tagged with the requester id and the tag travels down a pipe whose
// depth matches the memory read latency, so the response strobe lines up with
// mem_dout. Read data is a shared combinational passthrough of mem_dout.
module mem_port_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned ADDR   = 4,
   parameter int unsigned DATA   = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hold,
   input  logic [N-1:0]        req_valid,
   output logic [N-1:0]        req_ready,
   input  logic [N-1:0]        req_wr,
   input  logic [N*ADDR-1:0]   req_addr,
   input  logic [N*DATA-1:0]   req_wdata,
   output logic [N-1:0]        rsp_valid,
   output logic [DATA-1:0]     rsp_rdata,
   output logic                mem_wr,
   output logic [ADDR-1:0]     mem_addr,
   output logic [DATA-1:0]     mem_din,
   input  logic [DATA-1:0]     mem_dout,
   output logic                idle
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic [N-1:0]      cand;
   logic              gnt;
   logic [PW-1:0]     win;
   logic [31:0]       idx;
   logic [RD_LAT-1:0] tag_v_q;
   logic [PW-1:0]     tag_id_q [RD_LAT];

   // Reset and hold both remove every candidate, so no grant can leak out.
   assign cand = (hold || !rst_n) ? '0 : req_valid;

   // Rotating-priority search: first set candidate starting at ptr_q, wrapping mod N.
   always_comb begin
      gnt = 1'b0;
      win = '0;
      idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!gnt && cand[idx[PW-1:0]]) begin
            gnt = 1'b1;
            win = idx[PW-1:0];
         end
      end
   end

   // One-hot grant and memory command taken straight from the winner.
   always_comb begin
      req_ready = '0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      if (gnt) begin
         req_ready = {{(N-1){1'b0}}, 1'b1} << win;
         mem_wr    = req_wr[win];
         mem_addr  = req_addr[win*ADDR +: ADDR];
         mem_din   = req_wdata[win*DATA +: DATA];
      end
   end

   // Next pointer: one past the winner on an accept, otherwise frozen.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt) begin
         if (32'(win) == N - 1) ptr_d = '0;
         else                   ptr_d = win + 1'b1;
      end
   end

   // Pointer and read-tag pipe; reset drops every in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         tag_v_q <= '0;
         for (int k = 0; k < RD_LAT; k++) tag_id_q[k] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         tag_v_q[0]  <= gnt & ~mem_wr;
         tag_id_q[0] <= win;
         for (int k = 1; k < RD_LAT; k++) begin
            tag_v_q[k]  <= tag_v_q[k-1];
            tag_id_q[k] <= tag_id_q[k-1];
         end
      end
   end

   // Decode the last pipe stage into the per-requester response strobe.
   always_comb begin
      rsp_valid = '0;
      if (tag_v_q[RD_LAT-1]) rsp_valid[tag_id_q[RD_LAT-1]] = 1'b1;
   end

   assign rsp_rdata = mem_dout;
   assign idle      = ~gnt & ~(|tag_v_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 2) share the same
// stimulus, each backed by its own behavioural memory. A negedge monitor checks
// every cycle against a round-robin / scoreboard model; scenario tasks add
// directed checks.
module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n     = 1'b0;
   logic          hold      = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_wr    = '0;
   logic [N*AW-1:0] req_addr  = '0;
   logic [N*DW-1:0] req_wdata = '0;

   logic [N-1:0]  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
   logic [DW-1:0] a_rsp_rdata, b_rsp_rdata, a_mem_din, b_mem_din, a_mem_dout, b_mem_dout;
   logic [AW-1:0] a_mem_addr, b_mem_addr;
   logic          a_mem_wr, b_mem_wr, a_idle, b_idle;

   mem_port_arbiter #(.N(N), .ADDR(AW), .DATA(DW), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req_valid(req_valid), .req_ready(a_req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
      .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
      .mem_dout(a_mem_dout), .idle(a_idle)
   );

   mem_port_arbiter #(.N(N), .ADDR(AW), .DATA(DW), .RD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req_valid(req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
      .mem_dout(b_mem_dout), .idle(b_idle)
   );

   // Behavioural memories: command sampled on the accept edge, data after RD_LAT edges.
   logic [DW-1:0] mem_a [16];
   logic [DW-1:0] mem_b [16];
   logic [DW-1:0] rd_a, rd_b0, rd_b1;
   always @(posedge clk) begin
      if (a_mem_wr) mem_a[a_mem_addr] <= a_mem_din;
      rd_a <= mem_a[a_mem_addr];
      if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_din;
      rd_b0 <= mem_b[b_mem_addr];
      rd_b1 <= rd_b0;
   end
   assign a_mem_dout = rd_a;
   assign b_mem_dout = rd_b1;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
      bit            chk;
   } rsp_t;

   rsp_t          qa[$];
   rsp_t          qb[$];
   rsp_t          ent;
   int            refmem[16];
   bit            known[16];
   int            m_ptr = 0;
   int            m_win;
   int            m_idx;
   int            cyc = 0;
   bit            mon_en = 1'b0;
   logic [N-1:0]  exp_ready, exp_rv_a, exp_rv_b;
   logic          exp_wr;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_din, exp_rd_a, exp_rd_b;
   bit            exp_idle_a, exp_idle_b, chk_a, chk_b;

   always @(negedge clk) begin
      if (mon_en) begin
         cyc++;
         m_win = -1;
         exp_ready = '0;
         exp_wr = 1'b0;
         exp_addr = '0;
         exp_din = '0;
         if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_ptr = 0;
         end else if (!hold) begin
            for (int k = 0; k < N; k++) begin
               m_idx = (m_ptr + k) % N;
               if (m_win < 0 && req_valid[m_idx]) m_win = m_idx;
            end
         end
         if (m_win >= 0) begin
            exp_ready[m_win] = 1'b1;
            exp_wr   = req_wr[m_win];
            exp_addr = req_addr[m_win*AW +: AW];
            exp_din  = req_wdata[m_win*DW +: DW];
         end
         exp_idle_a = (exp_ready == '0) && (qa.size() == 0);
         exp_idle_b = (exp_ready == '0) && (qb.size() == 0);
         exp_rv_a = '0;
         exp_rv_b = '0;
         chk_a = 1'b0;
         chk_b = 1'b0;
         exp_rd_a = '0;
         exp_rd_b = '0;
         if (qa.size() > 0 && qa[0].due == cyc) begin
            ent = qa.pop_front();
            exp_rv_a[ent.id] = 1'b1;
            chk_a = ent.chk;
            exp_rd_a = ent.data;
         end
         if (qb.size() > 0 && qb[0].due == cyc) begin
            ent = qb.pop_front();
            exp_rv_b[ent.id] = 1'b1;
            chk_b = ent.chk;
            exp_rd_b = ent.data;
         end

         n_tests++;
         if (a_req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL mon_ready_a cyc=%0d: got %b expected %b", cyc, a_req_ready, exp_ready);
         end
         n_tests++;
         if (b_req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL mon_ready_b cyc=%0d: got %b expected %b", cyc, b_req_ready, exp_ready);
         end
         n_tests++;
         if ({a_mem_wr, a_mem_addr, a_mem_din} !== {exp_wr, exp_addr, exp_din}) begin
            n_fail++;
            $display("FAIL mon_mem_a cyc=%0d: got wr=%b addr=%0d din=%0d expected wr=%b addr=%0d din=%0d",
                     cyc, a_mem_wr, a_mem_addr, a_mem_din, exp_wr, exp_addr, exp_din);
         end
         n_tests++;
         if ({b_mem_wr, b_mem_addr, b_mem_din} !== {exp_wr, exp_addr, exp_din}) begin
            n_fail++;
            $display("FAIL mon_mem_b cyc=%0d: got wr=%b addr=%0d din=%0d expected wr=%b addr=%0d din=%0d",
                     cyc, b_mem_wr, b_mem_addr, b_mem_din, exp_wr, exp_addr, exp_din);
         end
         n_tests++;
         if (a_rsp_valid !== exp_rv_a) begin
            n_fail++;
            $display("FAIL mon_rsp_valid_a cyc=%0d: got %b expected %b", cyc, a_rsp_valid, exp_rv_a);
         end
         n_tests++;
         if (b_rsp_valid !== exp_rv_b) begin
            n_fail++;
            $display("FAIL mon_rsp_valid_b cyc=%0d: got %b expected %b", cyc, b_rsp_valid, exp_rv_b);
         end
         if (chk_a) begin
            n_tests++;
            if (a_rsp_rdata !== exp_rd_a) begin
               n_fail++;
               $display("FAIL mon_rdata_a cyc=%0d: got %0d expected %0d", cyc, a_rsp_rdata, exp_rd_a);
            end
         end
         if (chk_b) begin
            n_tests++;
            if (b_rsp_rdata !== exp_rd_b) begin
               n_fail++;
               $display("FAIL mon_rdata_b cyc=%0d: got %0d expected %0d", cyc, b_rsp_rdata, exp_rd_b);
            end
         end
         n_tests++;
         if (a_idle !== exp_idle_a) begin
            n_fail++;
            $display("FAIL mon_idle_a cyc=%0d: got %b expected %b", cyc, a_idle, exp_idle_a);
         end
         n_tests++;
         if (b_idle !== exp_idle_b) begin
            n_fail++;
            $display("FAIL mon_idle_b cyc=%0d: got %b expected %b", cyc, b_idle, exp_idle_b);
         end

         // Apply the accepted transaction to the model.
         if (m_win >= 0) begin
            m_ptr = (m_win + 1) % N;
            if (exp_wr) begin
               refmem[exp_addr] = int'(exp_din);
               known[exp_addr]  = 1'b1;
            end else begin
               ent.id   = m_win;
               ent.data = DW'(refmem[exp_addr]);
               ent.chk  = known[exp_addr];
               ent.due  = cyc + 1;
               qa.push_back(ent);
               ent.due  = cyc + 2;
               qb.push_back(ent);
            end
         end
      end
   end

   // ---------------- drive helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit wr, input int addr, input int data);
      req_valid[i] = 1'b1;
      req_wr[i]    = wr;
      req_addr[i*AW +: AW]  = AW'(addr);
      req_wdata[i*DW +: DW] = DW'(data);
   endtask

   task automatic clear_req(input int i);
      req_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'hF;
      req_wr = 4'hF;
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0 || b_req_ready !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b/%b expected 0000", a_req_ready, b_req_ready);
      end
      n_tests++;
      if (a_rsp_valid !== 4'b0 || b_rsp_valid !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_rsp_valid: got %b/%b expected 0000", a_rsp_valid, b_rsp_valid);
      end
      n_tests++;
      if ({a_mem_wr, a_mem_addr, a_mem_din} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_mem: got wr=%b addr=%0d din=%0d expected all 0", a_mem_wr, a_mem_addr,
                  a_mem_din);
      end
      n_tests++;
      if (a_idle !== 1'b1 || b_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_idle: got %b/%b expected 1", a_idle, b_idle);
      end
      tick();
      req_valid = '0;
      req_wr = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 3, 234);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0001 || a_mem_wr !== 1'b1 || a_mem_addr !== 4'd3 || a_mem_din !== 8'd234) begin
         n_fail++;
         $display("FAIL single_write: got ready=%b wr=%b addr=%0d din=%0d expected 0001 1 3 234",
                  a_req_ready, a_mem_wr, a_mem_addr, a_mem_din);
      end
      tick();
      set_req(0, 1'b0, 3, 0);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0001 || a_mem_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL single_read_grant: got ready=%b wr=%b expected 0001 0", a_req_ready, a_mem_wr);
      end
      tick();
      clear_req(0);
      @(negedge clk);
      n_tests++;
      if (a_rsp_valid !== 4'b0001 || a_rsp_rdata !== 8'd234) begin
         n_fail++;
         $display("FAIL single_read_rsp: got valid=%b data=%0d expected 0001 234", a_rsp_valid,
                  a_rsp_rdata);
      end
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) begin
         set_req(0, 1'b1, i, 10 + i);
         tick();
      end
      clear_req(0);
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         n_tests++;
         if (a_req_ready !== (4'b0001 << k)) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got %b expected %b", k, a_req_ready, 4'b0001 << k);
         end
         if (k > 0) begin
            n_tests++;
            if (a_rsp_valid !== (4'b0001 << (k - 1)) || a_rsp_rdata !== 8'(10 + k - 1)) begin
               n_fail++;
               $display("FAIL rr_rsp_%0d: got valid=%b data=%0d expected %b %0d", k - 1, a_rsp_valid,
                        a_rsp_rdata, 4'b0001 << (k - 1), 10 + k - 1);
            end
         end
         tick();
         clear_req(k);
      end
      @(negedge clk);
      n_tests++;
      if (a_rsp_valid !== 4'b1000 || a_rsp_rdata !== 8'd13) begin
         n_fail++;
         $display("FAIL rr_rsp_3: got valid=%b data=%0d expected 1000 13", a_rsp_valid, a_rsp_rdata);
      end
      tick();
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp;
      do_reset();
      set_req(0, 1'b0, 0, 0);
      set_req(2, 1'b0, 2, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp = (k % 2 == 0) ? 4'b0001 : 4'b0100;
         n_tests++;
         if (a_req_ready !== exp) begin
            n_fail++;
            $display("FAIL fair_grant_%0d: got %b expected %b", k, a_req_ready, exp);
         end
         tick();
      end
      clear_req(0);
      clear_req(2);
      tick();
   endtask

   task automatic test_hold();
      do_reset();
      set_req(0, 1'b0, 1, 0);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL hold_pre_grant: got %b expected 0001", a_req_ready);
      end
      tick();
      clear_req(0);
      hold = 1'b1;
      set_req(1, 1'b1, 5, 77);
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         n_tests++;
         if (a_req_ready !== 4'b0 || a_mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_blocked_%0d: got ready=%b wr=%b expected 0000 0", h, a_req_ready,
                     a_mem_wr);
         end
         if (h == 0) begin
            n_tests++;
            if (a_rsp_valid !== 4'b0001 || a_rsp_rdata !== 8'd11) begin
               n_fail++;
               $display("FAIL hold_inflight_rsp: got valid=%b data=%0d expected 0001 11",
                        a_rsp_valid, a_rsp_rdata);
            end
         end
         tick();
      end
      hold = 1'b0;
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0010 || a_mem_wr !== 1'b1 || a_mem_addr !== 4'd5) begin
         n_fail++;
         $display("FAIL hold_release_grant: got ready=%b wr=%b addr=%0d expected 0010 1 5",
                  a_req_ready, a_mem_wr, a_mem_addr);
      end
      tick();
      clear_req(1);
      tick();
   endtask

   task automatic test_reset_mid_read();
      set_req(2, 1'b0, 3, 0);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL rmid_grant: got %b expected 0100", a_req_ready);
      end
      tick();
      rst_n = 1'b0;
      clear_req(2);
      @(negedge clk);
      n_tests++;
      if (a_rsp_valid !== 4'b0 || b_rsp_valid !== 4'b0 || a_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_in_reset: got a=%b b=%b idle=%b expected 0000 0000 1", a_rsp_valid,
                  b_rsp_valid, a_idle);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (a_rsp_valid !== 4'b0 || b_rsp_valid !== 4'b0 || a_idle !== 1'b1 || b_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_after_release: got a=%b b=%b idle=%b/%b expected 0000 0000 1/1",
                  a_rsp_valid, b_rsp_valid, a_idle, b_idle);
      end
      tick();
      // ptr was 3 before the reset; a cleared ptr favours requester 0 over 3.
      set_req(0, 1'b0, 0, 0);
      set_req(3, 1'b0, 3, 0);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rmid_ptr_cleared: got %b expected 0001", a_req_ready);
      end
      tick();
      clear_req(0);
      @(negedge clk);
      n_tests++;
      if (a_req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rmid_next_grant: got %b expected 1000", a_req_ready);
      end
      tick();
      clear_req(3);
      tick();
   endtask

   task automatic test_rdlat2();
      do_reset();
      set_req(3, 1'b1, 15, 255);
      @(negedge clk);
      n_tests++;
      if (b_req_ready !== 4'b1000 || b_mem_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL lat2_write: got ready=%b wr=%b expected 1000 1", b_req_ready, b_mem_wr);
      end
      tick();
      set_req(3, 1'b0, 15, 0);
      @(negedge clk);
      n_tests++;
      if (b_req_ready !== 4'b1000 || b_mem_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL lat2_read_grant: got ready=%b wr=%b expected 1000 0", b_req_ready, b_mem_wr);
      end
      tick();
      clear_req(3);
      @(negedge clk);
      n_tests++;
      if (b_rsp_valid !== 4'b0) begin
         n_fail++;
         $display("FAIL lat2_early: got %b expected 0000", b_rsp_valid);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (b_rsp_valid !== 4'b1000 || b_rsp_rdata !== 8'd255) begin
         n_fail++;
         $display("FAIL lat2_rsp: got valid=%b data=%0d expected 1000 255", b_rsp_valid, b_rsp_rdata);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (b_rsp_valid !== 4'b0) begin
         n_fail++;
         $display("FAIL lat2_late: got %b expected 0000", b_rsp_valid);
      end
      tick();
   endtask

   task automatic test_random();
      int           wait_c[N];
      logic [N-1:0] gnt;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 45) begin
               set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)));
               wait_c[i] = 0;
            end
         end
         hold  = ($urandom_range(0, 99) < 10);
         rst_n = ($urandom_range(0, 199) != 0);
         @(negedge clk);
         gnt = a_req_ready;
         for (int i = 0; i < N; i++) begin
            if (!rst_n) wait_c[i] = 0;
            else if (req_valid[i] && !hold) begin
               if (gnt[i]) wait_c[i] = 0;
               else        wait_c[i]++;
               n_tests++;
               if (wait_c[i] >= N) begin
                  n_fail++;
                  $display("FAIL rand_starve req%0d: waited %0d cycles, limit %0d", i, wait_c[i], N - 1);
               end
            end
         end
         tick();
         for (int i = 0; i < N; i++) if (gnt[i]) clear_req(i);
      end
      req_valid = '0;
      hold = 1'b0;
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         refmem[i] = 0;
         known[i]  = 1'b0;
      end
      mon_en = 1'b1;
      repeat (2) tick();
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_hold();
      test_reset_mid_read();
      test_rdlat2();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one port (A or B) of the dual-port `memory` block among N independent requesters.
- Each requester uses a valid/ready request channel; reads return through a per-requester response-valid strobe, aligned to the memory's read latency.
- Sits between compute/DMA engines and the memory. Two instances, one per port, give up to 2N shared clients.

Parameters:
- N, 4, number of requesters (2..8).
- ADDR, 4, address width; must match the memory instance.
- DATA, 8, data width; must match the memory instance.
- RD_LAT, 1, cycles from the accepting clock edge to `mem_dout` valid (1..4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hold  input  1  when high, no new grants are issued; in-flight reads still complete.
- req_valid  input  N  request valid, bit i = requester i.
- req_ready  output  N  one-hot or zero; grant for this cycle.
- req_wr  input  N  1 = write, 0 = read.
- req_addr  input  N*ADDR  address; slice i = [i*ADDR +: ADDR].
- req_wdata  input  N*DATA  write data; slice i = [i*DATA +: DATA].
- rsp_valid  output  N  read data valid for requester i.
- rsp_rdata  output  DATA  shared read data; valid only with a `rsp_valid` bit set.
- mem_wr  output  1  to memory `x_wr`.
- mem_addr  output  ADDR  to memory `x_addr`.
- mem_din  output  DATA  to memory `x_din`.
- mem_dout  input  DATA  from memory `x_dout`.
- idle  output  1  high when no grant this cycle and no reads in flight.

Behaviour:
- **State:**
  - `ptr` (clog2(N) bits): highest-priority requester index.
  - `tag_pipe`: RD_LAT stages, each holding {valid, id}.
- **Reset (rst_n low, asynchronous):**
  - `ptr` = 0; all `tag_pipe` valid bits = 0.
  - Outputs: `req_ready` = 0, `rsp_valid` = 0, `mem_wr` = 0, `idle` = 1.
  - `mem_addr` and `mem_din` = 0.
- **Grant (combinational):**
  - Candidates are the set bits of `req_valid`, unless `hold` = 1 or reset is asserted (then no candidates).
  - Winner = first set bit searching `ptr`, `ptr`+1, ... modulo N.
  - `req_ready` = one-hot winner, or 0 if no candidate.
  - `req_ready` may depend on `req_valid`.
  - Requesters must hold valid/wr/addr/wdata stable until ready.
- **Memory drive (combinational from the winner):**
  - `mem_wr` = winner's `req_wr`, else 0.
  - `mem_addr` and `mem_din` = winner's slices, else 0.
  - The memory samples the command on the same edge that completes the handshake (accept edge).
- **Pointer update:** on an accept edge, `ptr` <= (winner + 1) mod N. With no grant, `ptr` holds.
- **Read response:**
  - An accepted read pushes {1, winner} into `tag_pipe` stage 0. Writes and idle cycles push {0, x}.
  - The pipe shifts every cycle.
  - `rsp_valid[id]` = valid bit of the last stage, registered. It is therefore high exactly in the cycle after edge t+RD_LAT-1, where t is the accept edge.
  - `rsp_rdata` = `mem_dout`, combinational passthrough.
  - RD_LAT=1: response in the cycle immediately after the accept edge.
- **Throughput:** one request per cycle total; back-to-back reads yield back-to-back responses in grant order.
- **Writes:** no response; read-after-write to the same address by a later grant returns the new data.
- **Hold:** asserting `hold` blocks new grants from the same cycle. Reads already in the pipe still deliver `rsp_valid`. `ptr` is frozen.
- **Starvation bound:** a continuously valid requester is granted within N cycles of `hold` being low.
- **`idle`:** high iff `req_ready` = 0 and all `tag_pipe` valid bits = 0.
- **Reset mid-operation:** in-flight reads are discarded; no `rsp_valid` is produced for them after release.

Test Plan:
- **Single requester (N=4, ADDR=4, DATA=8, RD_LAT=1):** req0 writes addr 3 = 234, then reads addr 3 -> `req_ready[0]` in the same cycle as each valid; `rsp_valid` = 4'b0001 one cycle after the read accept; `rsp_rdata` = 234.
- **Round-robin order:** prefill addr 0..3 with 10, 11, 12, 13; all four requesters read their own index simultaneously, `ptr` = 0 -> grants 0, 1, 2, 3 on consecutive cycles; responses 10, 11, 12, 13 on consecutive cycles with matching `rsp_valid` bits.
- **Fairness:** req0 and req2 continuously valid for 6 cycles -> grant sequence 0, 2, 0, 2, 0, 2; `req_ready[1]` and `req_ready[3]` never set.
- **Hold:** read in flight, then `hold` = 1 for 3 cycles with req1 valid -> the in-flight `rsp_valid` still fires; `req_ready` = 0 and `mem_wr` = 0 throughout hold; req1 is granted in the first cycle after `hold` = 0.
- **Reset mid-read:** read accepted, `rst_n` pulsed low before the response cycle -> `rsp_valid` stays 0; `ptr` = 0; `idle` = 1.
- **RD_LAT=2 instance:** read of addr 15 = 255 by req3 -> `rsp_valid[3]` exactly two cycles after the accept edge; `rsp_rdata` = 255.
